// File: rtl/dense_layer_pkg.sv
// Shared types and width/saturation helpers for the dense layer datapath.
//   state_e    : FSM encoding (IDLE, LOAD, BIAS, MAC, OUT)
//   acc_width  : accumulator width that cannot overflow for a given input count
//   sat_max/min: signed output range for a given data width
package dense_layer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIAS,
    ST_MAC,
    ST_OUT
  } state_e;

  // Full-precision product plus growth for in_count additions and the bias term.
  function automatic int unsigned acc_width(input int unsigned data_size,
                                            input int unsigned in_count);
    return 2 * data_size + $clog2(in_count) + 1;
  endfunction

  function automatic longint sat_max(input int unsigned data_size);
    return (longint'(1) <<< (data_size - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned data_size);
    return -(longint'(1) <<< (data_size - 1));
  endfunction

endpackage

// File: rtl/param_ram.sv
// Single-port parameter RAM for weights or biases.
//   clk     : write clock
//   rd      : read enable; dataOut is 0 when low
//   wr      : synchronous write enable
//   adr     : word address
//   dataIn  : write data
//   dataOut : combinational read data, mem[adr]
module param_ram #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned ADR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             wr,
  input  logic [ADR_W-1:0] adr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Address range guard: DEPTH need not be a power of two.
  logic in_range_c;
  assign in_range_c = (32'(adr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr && in_range_c) begin
      mem[adr] <= dataIn;
    end
  end

  assign dataOut = (rd && in_range_c) ? mem[adr] : '0;

endmodule

// File: rtl/dense_layer.sv
// Fully-connected layer: buffers IN_COUNT activations, then for each neuron o
// loads bias[o], accumulates in[i]*w[o*IN_COUNT+i] and emits a saturated result.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin inference (accepted only in IDLE)
//   dataIn     : activation stream, one value per cycle after the start edge
//   weightData : weight read at weightAdr (external RAM, combinational)
//   biasData   : bias read at biasAdr (external RAM, combinational)
//   busy       : inference in progress
//   valid      : one-cycle strobe per output
//   dataOut    : last emitted output
//   weightAdr  : flat weight index o*IN_COUNT+i
//   biasAdr    : bias index o
module dense_layer
  import dense_layer_pkg::*;
#(
  parameter int unsigned IN_COUNT  = 10,
  parameter int unsigned OUT_COUNT = 3,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [DATA_SIZE-1:0]                   dataIn,
  input  logic [DATA_SIZE-1:0]                   weightData,
  input  logic [DATA_SIZE-1:0]                   biasData,
  output logic                                   busy,
  output logic                                   valid,
  output logic [DATA_SIZE-1:0]                   dataOut,
  output logic [$clog2(IN_COUNT*OUT_COUNT)-1:0]  weightAdr,
  output logic [$clog2(OUT_COUNT)-1:0]           biasAdr
);

  localparam int unsigned WADR_W = $clog2(IN_COUNT * OUT_COUNT);
  localparam int unsigned BADR_W = $clog2(OUT_COUNT);
  localparam int unsigned CNT_W  = $clog2(IN_COUNT + 1);
  localparam int unsigned PROD_W = 2 * DATA_SIZE;
  localparam int unsigned ACC_W  = acc_width(DATA_SIZE, IN_COUNT);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_SIZE));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DATA_SIZE));

  state_e                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [BADR_W-1:0]            o_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [DATA_SIZE-1:0]  in_buf_q [IN_COUNT];
  logic                         busy_q;
  logic                         valid_q;
  logic [DATA_SIZE-1:0]         dout_q;
  logic [WADR_W-1:0]            wadr_q;
  logic [BADR_W-1:0]            badr_q;

  // Datapath: product of buffered activation and current weight, running sum, saturation.
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      prod_ext_c;
  logic signed [ACC_W-1:0]      mac_sum_c;
  logic signed [ACC_W-1:0]      bias_ext_c;
  logic signed [ACC_W-1:0]      shifted_c;
  logic [DATA_SIZE-1:0]         sat_c;

  assign prod_c     = PROD_W'(in_buf_q[cnt_q]) * PROD_W'($signed(weightData));
  assign prod_ext_c = ACC_W'(prod_c);
  assign mac_sum_c  = acc_q + prod_ext_c;
  assign bias_ext_c = ACC_W'($signed(biasData)) <<< FRAC_BITS;

  always_comb begin
    shifted_c = mac_sum_c >>> FRAC_BITS;
    sat_c     = shifted_c[DATA_SIZE-1:0];
    if (shifted_c > SAT_MAX) begin
      sat_c = SAT_MAX[DATA_SIZE-1:0];
    end else if (shifted_c < SAT_MIN) begin
      sat_c = SAT_MIN[DATA_SIZE-1:0];
    end
  end

  // Control FSM. LOAD spends one extra cycle after the last capture so biasAdr
  // is registered ahead of BIAS; the final MAC edge writes dataOut directly so
  // valid and dataOut rise together on entry to OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      wadr_q  <= '0;
      badr_q  <= '0;
      for (int unsigned k = 0; k < IN_COUNT; k++) begin
        in_buf_q[k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            o_q     <= '0;
          end
        end
        ST_LOAD: begin
          if (cnt_q == CNT_W'(IN_COUNT)) begin
            state_q <= ST_BIAS;
            badr_q  <= o_q;
            cnt_q   <= '0;
          end else begin
            in_buf_q[cnt_q] <= $signed(dataIn);
            cnt_q           <= cnt_q + CNT_W'(1);
          end
        end
        ST_BIAS: begin
          acc_q   <= bias_ext_c;
          wadr_q  <= WADR_W'(32'(o_q) * IN_COUNT);
          cnt_q   <= '0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          acc_q <= mac_sum_c;
          if (cnt_q == CNT_W'(IN_COUNT - 1)) begin
            state_q <= ST_OUT;
            valid_q <= 1'b1;
            dout_q  <= sat_c;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            wadr_q <= wadr_q + WADR_W'(1);
          end
        end
        ST_OUT: begin
          if (o_q == BADR_W'(OUT_COUNT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            o_q     <= o_q + BADR_W'(1);
            badr_q  <= o_q + BADR_W'(1);
            state_q <= ST_BIAS;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign dataOut   = dout_q;
  assign weightAdr = wadr_q;
  assign biasAdr   = badr_q;

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer with external weight/bias RAMs and an
// expected-output queue popped on every valid strobe.
module tb_dense_layer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dataIn;
  logic [7:0] weightData;
  logic [7:0] biasData;
  logic       busy;
  logic       valid;
  logic [7:0] dataOut;
  logic [4:0] weightAdr;
  logic [1:0] biasAdr;

  logic       tb_load;
  logic       w_wr;
  logic       b_wr;
  logic [4:0] tb_adr;
  logic [7:0] tb_din;
  logic [4:0] w_adr;
  logic [1:0] b_adr;

  assign w_adr = tb_load ? tb_adr : weightAdr;
  assign b_adr = tb_load ? tb_adr[1:0] : biasAdr;

  param_ram #(.WIDTH(8), .DEPTH(30)) u_wram (
    .clk(clk), .rd(1'b1), .wr(w_wr), .adr(w_adr), .dataIn(tb_din), .dataOut(weightData)
  );

  param_ram #(.WIDTH(8), .DEPTH(3)) u_bram (
    .clk(clk), .rd(1'b1), .wr(b_wr), .adr(b_adr), .dataIn(tb_din), .dataOut(biasData)
  );

  dense_layer #(10, 3, 8, 0) dut (
    .clk(clk), .rst(rst), .start(start), .dataIn(dataIn),
    .weightData(weightData), .biasData(biasData),
    .busy(busy), .valid(valid), .dataOut(dataOut),
    .weightAdr(weightAdr), .biasAdr(biasAdr)
  );

  always #3 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int ncyc        = 0;
  int strobes     = 0;
  int strobe_base = 0;
  int first_vcyc  = -1;
  int last_vcyc   = -1;
  int start_cyc   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] in_vec [10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One cycle: sample at the falling edge, score any valid strobe.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    ncyc++;
    if (valid === 1'b1) begin
      strobes++;
      if (first_vcyc < 0) first_vcyc = ncyc;
      last_vcyc = ncyc;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dataOut", 32'(dataOut), 32'(e));
      end
    end
  endtask

  task automatic wr_word(input bit to_bias, input int unsigned adr, input logic [7:0] v);
    tb_load = 1'b1;
    tb_adr  = 5'(adr);
    tb_din  = v;
    w_wr    = !to_bias;
    b_wr    = to_bias;
    tick();
    w_wr    = 1'b0;
    b_wr    = 1'b0;
    tb_load = 1'b0;
  endtask

  task automatic fill_weights(input logic [7:0] v);
    for (int i = 0; i < 30; i++) wr_word(1'b0, i, v);
  endtask

  task automatic fill_biases(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    wr_word(1'b1, 0, b0);
    wr_word(1'b1, 1, b1);
    wr_word(1'b1, 2, b2);
  endtask

  task automatic push3(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  // Pulse start and stream in_vec on the ten edges after the start edge.
  task automatic start_feed();
    start_cyc   = ncyc;
    first_vcyc  = -1;
    last_vcyc   = -1;
    strobe_base = strobes;
    start = 1'b1;
    tick();
    start  = 1'b0;
    dataIn = in_vec[0];
    for (int k = 1; k < 10; k++) begin
      tick();
      dataIn = in_vec[k];
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy === 1'b1 || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < 200), 32'd1);
    check({tag, "_strobes"}, 32'(strobes - strobe_base), 32'd3);
    check({tag, "_first_valid_latency"}, 32'(first_vcyc - start_cyc), 32'd23);
    check({tag, "_strobe_spacing"}, 32'(last_vcyc - first_vcyc), 32'd24);
    check({tag, "_weightAdr_hold"}, 32'(weightAdr), 32'd29);
    check({tag, "_biasAdr_hold"}, 32'(biasAdr), 32'd2);
  endtask

  task automatic run(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                     input logic [7:0] e2);
    push3(e0, e1, e2);
    start_feed();
    drain(tag);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    dataIn  = '0;
    tb_load = 1'b0;
    w_wr    = 1'b0;
    b_wr    = 1'b0;
    tb_adr  = '0;
    tb_din  = '0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_dataOut", 32'(dataOut), 32'd0);
    check("reset_weightAdr", 32'(weightAdr), 32'd0);
    check("reset_biasAdr", 32'(biasAdr), 32'd0);
    rst = 1'b0;
    tick();

    // Unit weights, zero biases: each neuron sums 1..10.
    for (int k = 0; k < 10; k++) in_vec[k] = 8'(k + 1);
    fill_weights(8'h01);
    fill_biases(8'h00, 8'h00, 8'h00);
    run("s1", 8'h37, 8'h37, 8'h37);

    // Second start during MAC must be ignored.
    push3(8'h37, 8'h37, 8'h37);
    start_feed();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("s5");

    // Reset mid-MAC discards the inference.
    push3(8'h37, 8'h37, 8'h37);
    start_feed();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_valid", 32'(valid), 32'd0);
    check("s6_rst_dataOut", 32'(dataOut), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    strobe_base = strobes;
    repeat (40) tick();
    check("s6_no_valid_after_reset", 32'(strobes - strobe_base), 32'd0);
    run("s6_fresh", 8'h37, 8'h37, 8'h37);

    // Negative weights with mixed-sign biases: -55 + {0, 5, -5}.
    fill_weights(8'hFF);
    fill_biases(8'h00, 8'h05, 8'hFB);
    run("s2", 8'hC9, 8'hCE, 8'hC4);

    // Saturation at both ends.
    for (int k = 0; k < 10; k++) in_vec[k] = 8'h7F;
    fill_weights(8'h7F);
    fill_biases(8'h00, 8'h00, 8'h00);
    run("s3_pos", 8'h7F, 8'h7F, 8'h7F);
    fill_weights(8'h80);
    run("s3_neg", 8'h80, 8'h80, 8'h80);

    // Zero weights pass the biases straight through.
    for (int k = 0; k < 10; k++) in_vec[k] = 8'(k + 1);
    fill_weights(8'h00);
    fill_biases(8'h05, 8'hFD, 8'h7F);
    run("s4", 8'h05, 8'hFD, 8'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
